// File: rtl/cpu_defs.sv
// Shared CPU definitions: CP0 register numbers, exception codes, CP0 field layouts
// and the WB-to-CP0 commit bus.
package cpu_defs;

  localparam logic [4:0] CR_BADVADDR = 5'd8;
  localparam logic [4:0] CR_COUNT    = 5'd9;
  localparam logic [4:0] CR_COMPARE  = 5'd11;
  localparam logic [4:0] CR_STATUS   = 5'd12;
  localparam logic [4:0] CR_CAUSE    = 5'd13;
  localparam logic [4:0] CR_EPC      = 5'd14;

  localparam logic [4:0] EXCCODE_INT  = 5'h00;
  localparam logic [4:0] EXCCODE_ADEL = 5'h04;
  localparam logic [4:0] EXCCODE_ADES = 5'h05;
  localparam logic [4:0] EXCCODE_SYS  = 5'h08;
  localparam logic [4:0] EXCCODE_BP   = 5'h09;
  localparam logic [4:0] EXCCODE_RI   = 5'h0a;
  localparam logic [4:0] EXCCODE_OV   = 5'h0c;

  typedef struct packed {
    logic       bev;
    logic [7:0] im;
    logic       exl;
    logic       ie;
  } cp0_status_t;

  // ip[7:2] is hardware-sampled, ip[1:0] is the software-writable pair
  typedef struct packed {
    logic       bd;
    logic [7:0] ip;
    logic [4:0] exccode;
  } cp0_cause_t;

  typedef struct packed {
    logic        bd;
    logic        ex;
    logic [4:0]  exccode;
    logic [31:0] badvaddr;
  } ws_exception_t;

  typedef struct packed {
    logic          eret_flush;
    ws_exception_t exception;
    logic [31:0]   pc;
  } ws_to_c0_bus_t;

  function automatic logic [31:0] status_word(input cp0_status_t s);
    return {9'b0, s.bev, 6'b0, s.im, 6'b0, s.exl, s.ie};
  endfunction

  function automatic logic [31:0] cause_word(input cp0_cause_t c, input logic ti);
    return {c.bd, ti, 14'b0, c.ip, 1'b0, c.exccode, 2'b0};
  endfunction

endpackage

// File: rtl/wb_c0_if.sv
// MTC0/MFC0 handshake between the WB stage (initiator) and CP0 (responder).
interface WB_C0_Interface;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport WB (output we, output addr, output wdata, input rdata);
  modport C0 (input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/cp0_regfile_timer.sv
// CP0 Count/Compare timer: half-clock-rate Count, Compare match raises sticky TI.
// Only present when CP0_TIMER_EN is defined.
`ifdef CP0_TIMER_EN
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic        tick_q, tick_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;

  always_comb begin
    tick_d    = ~tick_q;
    count_d   = count_q + {31'b0, tick_q};
    compare_d = compare_q;
    ti_d      = ti_q;
    if (count_we) begin
      count_d = wdata;
      tick_d  = 1'b0;
    end
    // a Compare write acknowledges the interrupt even if it matches this cycle
    if (compare_we) begin
      compare_d = wdata;
      ti_d      = 1'b0;
    end else if (count_d == compare_q) begin
      ti_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q    <= 1'b0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;

endmodule
`endif

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: MTC0/MFC0 responder, exception/ERET commit, interrupt request.
// Define CP0_TIMER_EN to include the Count/Compare timer; otherwise they read 0 and TI is 0.
module cp0_regfile
  import cpu_defs::*;
#(
  parameter logic [31:0] EX_VEC_BEV = 32'hBFC0_0380,
  parameter logic [31:0] EX_VEC     = 32'h8000_0180
) (
  input  logic           clk,
  input  logic           reset,
  WB_C0_Interface.C0     c0,
  input  ws_to_c0_bus_t  ws_to_c0_bus,
  input  logic [5:0]     ext_int_in,
  output logic           has_int,
  output logic [31:0]    ex_entry,
  output logic [31:0]    c0_epc
);

  localparam cp0_status_t STATUS_RST = '{bev: 1'b1, im: 8'h00, exl: 1'b0, ie: 1'b0};

  cp0_status_t status_q, status_d;
  cp0_cause_t  cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  logic [4:0]  reg_num;
  logic        sel_ok;
  logic        ex_commit;
  logic        eret_commit;
  logic        mtc0;
  logic [31:0] timer_count;
  logic [31:0] timer_compare;
  logic        timer_ti;
  logic [31:0] rdata;

  assign reg_num     = c0.addr[7:3];
  assign sel_ok      = (c0.addr[2:0] == 3'd0);
  assign ex_commit   = ws_to_c0_bus.exception.ex;
  assign eret_commit = ws_to_c0_bus.eret_flush & ~ex_commit;
  // a WB commit flushes the instruction carrying the MTC0, so its write is dropped
  assign mtc0        = c0.we & sel_ok & ~ex_commit & ~ws_to_c0_bus.eret_flush;

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (mtc0 && reg_num == CR_COUNT),
    .compare_we (mtc0 && reg_num == CR_COMPARE),
    .wdata      (c0.wdata),
    .count      (timer_count),
    .compare    (timer_compare),
    .ti         (timer_ti)
  );
`else
  assign timer_count   = '0;
  assign timer_compare = '0;
  assign timer_ti      = 1'b0;
`endif

  always_comb begin
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    cause_d.ip[7:2] = {ext_int_in[5] | timer_ti, ext_int_in[4:0]};
    if (ex_commit) begin
      cause_d.exccode = ws_to_c0_bus.exception.exccode;
      // nested exceptions keep the original return point
      if (!status_q.exl) begin
        epc_d      = ws_to_c0_bus.exception.bd ? ws_to_c0_bus.pc - 32'd4 : ws_to_c0_bus.pc;
        cause_d.bd = ws_to_c0_bus.exception.bd;
      end
      status_d.exl = 1'b1;
      if (ws_to_c0_bus.exception.exccode == EXCCODE_ADEL ||
          ws_to_c0_bus.exception.exccode == EXCCODE_ADES) begin
        badvaddr_d = ws_to_c0_bus.exception.badvaddr;
      end
    end else if (eret_commit) begin
      status_d.exl = 1'b0;
    end else if (mtc0) begin
      case (reg_num)
        CR_STATUS: begin
          status_d.im  = c0.wdata[15:8];
          status_d.exl = c0.wdata[1];
          status_d.ie  = c0.wdata[0];
        end
        CR_CAUSE: cause_d.ip[1:0] = c0.wdata[9:8];
        CR_EPC:   epc_d = c0.wdata;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q   <= STATUS_RST;
      cause_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel_ok) begin
      case (reg_num)
        CR_BADVADDR: rdata = badvaddr_q;
        CR_COUNT:    rdata = timer_count;
        CR_COMPARE:  rdata = timer_compare;
        CR_STATUS:   rdata = status_word(status_q);
        CR_CAUSE:    rdata = cause_word(cause_q, timer_ti);
        CR_EPC:      rdata = epc_q;
        default:     rdata = '0;
      endcase
    end
  end

  assign c0.rdata = rdata;
  assign has_int  = (|(cause_q.ip & status_q.im)) & status_q.ie & ~status_q.exl;
  assign ex_entry = status_q.bev ? EX_VEC_BEV : EX_VEC;
  assign c0_epc   = epc_q;

endmodule
